window_gen_3x3: RTL
===================

# window_gen_3x3

Streaming 3x3 window generator that produces the nine-operand input to `Convo_Core_3x3`. It accepts one raster-order FP32 pixel per valid cycle, buffers the two previous image rows, and presents a full 3x3 neighbourhood on `Data_Out0..Data_Out8` together with `Valid_Out`. Output ordering matches the `Kernel0..Kernel8` ordering of the core, so the two blocks wire port-to-port. Only valid (unpadded) windows are emitted: `(IMG_WIDTH-2)*(IMG_HEIGHT-2)` per frame.

## Interface
- `DATA_WIDHT`, 32: pixel width in bits. Data is opaque; no arithmetic is performed on it.
- `IMG_WIDTH`, 28: pixels per row. Legal range ≥3.
- `IMG_HEIGHT`, 28: rows per frame. Legal range ≥3.
- `clk` input 1: single clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `Valid_In` input 1: `Data_In` carries a pixel this cycle.
- `Data_In` input DATA_WIDHT: pixel, raster order (row-major, left to right).
- `Data_Out0`..`Data_Out8` output DATA_WIDHT each: window, row-major. `Data_Out0` = (r-2,c-2), `Data_Out4` = (r-1,c-1), `Data_Out8` = (r,c) = newest pixel.
- `Valid_Out` output 1: the window is valid this cycle. One-cycle pulse per window.
- `Frame_Done` output 1: one-cycle pulse, coincident with the window of the last pixel of the frame.

## Operation
- Counters:
  - `col` counts 0..IMG_WIDTH-1.
  - `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on `Valid_In`.
  - `col` wraps to 0 and increments `row` when `col` = IMG_WIDTH-1.
  - `row` wraps to 0 after the last pixel, so the next frame starts at (0,0) with no idle cycle.
- Line buffers:
  - There are two buffers, each IMG_WIDTH deep.
  - On each accepted pixel, LB1 outputs the pixel from one row above and LB0 outputs the pixel from two rows above.
  - On the same cycle, `Data_In` is written into LB1 and LB1's old output is written into LB0.
  - Buffers may be shift registers or a RAM with a shared column address. Their contents need no reset.
- Window registers:
  - A 3x3 register array.
  - On each accepted pixel, every row shifts left by one column.
  - The new right column is {LB0 output, LB1 output, `Data_In`}.
  - The array holds when `Valid_In`=0.
- State machine:
  - FILL: `row` < 2. No windows emitted. Enter FILL from reset and after every frame wrap.
  - ACTIVE: `row` ≥ 2. A window is emitted for each accepted pixel with `col` ≥ 2.
  - Transition FILL→ACTIVE occurs when the pixel at (1, IMG_WIDTH-1) is accepted.
  - Transition ACTIVE→FILL occurs when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- Windows never span a row boundary: `col` < 2 is suppressed in every row. Stale data from the previous row or frame in the window registers is therefore never exposed.
- No backpressure. The consumer must accept every `Valid_Out`, as the core does.

## Timing
- Reset values: `Data_Out0..8` = 0, `Valid_Out` = 0, `Frame_Done` = 0, `col` = 0, `row` = 0, state = FILL.
- Latency: a pixel accepted on edge N with (row ≥ 2, col ≥ 2) gives a registered window and `Valid_Out`=1 in the cycle after edge N. That is one cycle of latency.
- `Valid_Out` deasserts on the next edge unless another qualifying pixel is accepted. `Data_Out*` hold their last window while `Valid_Out`=0.
- Input gaps (`Valid_In`=0) of any length freeze all state and do not corrupt windows. Output windows are identical to the gap-free case, only spread in time.
- Full-rate throughput: 1 window per cycle in ACTIVE for columns ≥2. The (IMG_WIDTH-2)-window bursts per row are separated by 2 suppressed cycles.
- Reset mid-frame (rst asserted at any cycle):
  - Outputs clear immediately (asynchronous).
  - Counters return to (0,0) and the next accepted pixel is treated as (0,0) of a new frame.
  - Buffered line data is discarded logically; no window mixing pre-reset data is emitted.
- `Frame_Done` and the final `Valid_Out` of a frame are asserted in the same cycle. If the first pixel of the next frame is accepted in that same cycle, it is treated as pixel (0,0).

## Test plan
- **Basic 4x4 frame:** `IMG_WIDTH`=`IMG_HEIGHT`=4, pixels 32'h1..32'h10 continuous.
  - Exactly 4 `Valid_Out` pulses.
  - Windows: {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12}, {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16} on `Data_Out0..8`.
  - The first window appears one cycle after pixel 11 is accepted.
  - `Frame_Done` pulses with the last window.
- **Gapped input:** same frame with `Valid_In` randomly low about 50% of cycles.
  - Identical 4 windows in order.
  - `Valid_Out` is never asserted in a cycle after a gap cycle.
- **Back-to-back frames:** two 4x4 frames with no gap, the second using values 32'h101..32'h110.
  - 8 windows total.
  - The first window of frame 2 is {101,102,103,105,106,107,109,10A,10B}, with no frame-1 values.
- **Mid-frame reset:** pulse `rst` after pixel 7, then send a full 4x4 frame 32'h21..32'h30.
  - Outputs read 0 during reset.
  - Exactly 4 windows follow, the first being {21,22,23,25,26,27,29,2A,2B}.
- **Minimum size and chaining:** 3x3 frame, values 1..9, with `Data_Out*` driven into `Convo_Core_3x3` using the core's existing kernels.
  - One window {1..9}.
  - One `Frame_Done`.
  - Core `Valid_Out` follows.
- **Non-square frame:** `IMG_WIDTH`=5, `IMG_HEIGHT`=3, values 1..15.
  - Windows {1,2,3,6,7,8,11,12,13}, {2,3,4,7,8,9,12,13,14}, {3,4,5,8,9,10,13,14,15}.
  - No other `Valid_Out`.

Source files
------------

// File: rtl/window_gen_3x3.sv
// Purpose : streaming 3x3 neighbourhood generator over a raster-order pixel stream,
//           feeding the nine-operand input of Convo_Core_3x3 port-to-port.
// Latency : one cycle from accepting pixel (r>=2, c>=2) to its registered window.
// Backpr. : none; every Valid_Out pulse must be consumed in the cycle it appears.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   Valid_In, Data_In - one pixel per valid cycle, row-major raster order
//   Data_Out0..8      - window, row-major: 0 = (r-2,c-2), 4 = (r-1,c-1), 8 = (r,c)
//   Valid_Out         - one-cycle pulse per emitted window
//   Frame_Done        - pulses together with the last window of a frame
module window_gen_3x3 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Valid_In,
    input  logic [DATA_WIDHT-1:0] Data_In,
    output logic [DATA_WIDHT-1:0] Data_Out0,
    output logic [DATA_WIDHT-1:0] Data_Out1,
    output logic [DATA_WIDHT-1:0] Data_Out2,
    output logic [DATA_WIDHT-1:0] Data_Out3,
    output logic [DATA_WIDHT-1:0] Data_Out4,
    output logic [DATA_WIDHT-1:0] Data_Out5,
    output logic [DATA_WIDHT-1:0] Data_Out6,
    output logic [DATA_WIDHT-1:0] Data_Out7,
    output logic [DATA_WIDHT-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO   = CW'(2);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    typedef enum logic {
        S_FILL   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          emit;
    logic          frame_end;

    // Line buffers as column-addressed memories: reading the old entry at the
    // current column gives the same column one (lb1) or two (lb0) rows up.
    logic [DATA_WIDHT-1:0] lb1_mem [0:IMG_WIDTH-1];
    logic [DATA_WIDHT-1:0] lb0_mem [0:IMG_WIDTH-1];
    logic [DATA_WIDHT-1:0] lb1_out;
    logic [DATA_WIDHT-1:0] lb0_out;

    logic [DATA_WIDHT-1:0] win     [0:2][0:2];
    logic [DATA_WIDHT-1:0] win_nxt [0:2][0:2];
    logic [DATA_WIDHT-1:0] dout    [0:8];

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FILL / ACTIVE sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_FILL: begin
                if (Valid_In && (row == ROW_ONE) && col_last) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Columns 0 and 1 still hold previous-row pixels in the
                // window's left columns, so they are never emitted.
                if (Valid_In && (col >= COL_TWO)) begin
                    emit = 1'b1;
                end
                if (Valid_In && row_last && col_last) begin
                    state_nxt = S_FILL;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_nxt = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line buffers: read-before-write at the current column. Contents are
    // never reset; FILL guarantees two fresh rows before any window uses them.
    // ------------------------------------------------------------------
    assign lb1_out = lb1_mem[col];
    assign lb0_out = lb0_mem[col];

    always_ff @(posedge clk) begin
        if (Valid_In) begin
            lb1_mem[col] <= Data_In;
            lb0_mem[col] <= lb1_out;
        end
    end

    // ------------------------------------------------------------------
    // Window shift: each row moves left, new right column comes from the
    // two line buffers and the incoming pixel.
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
            win_nxt[r][2] = win[r][2];
        end
        win_nxt[0][2] = lb0_out;
        win_nxt[1][2] = lb1_out;
        win_nxt[2][2] = Data_In;
    end

    always_ff @(posedge clk) begin
        if (Valid_In) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= win_nxt[r][c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: loaded from the post-shift window so the window of
    // the pixel accepted on this edge is presented one cycle later, and held
    // between emitted windows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                dout[k] <= '0;
            end
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= emit;
            Frame_Done <= frame_end;
            if (emit) begin
                for (int k = 0; k < 9; k++) begin
                    dout[k] <= win_nxt[k / 3][k % 3];
                end
            end
        end
    end

    assign Data_Out0 = dout[0];
    assign Data_Out1 = dout[1];
    assign Data_Out2 = dout[2];
    assign Data_Out3 = dout[3];
    assign Data_Out4 = dout[4];
    assign Data_Out5 = dout[5];
    assign Data_Out6 = dout[6];
    assign Data_Out7 = dout[7];
    assign Data_Out8 = dout[8];

endmodule
